// File: rtl/ant_pkg.sv
// ---------------------------------------------------------------------------
// ant_pkg
// Shared constants and types for the ANT heart-rate-monitor frame parser.
//   ANT_SYNC      : sync byte that opens every ANT frame
//   ANT_MSG_BCAST : broadcast-data message id carrying HRM pages
//   HRM_LEN       : payload length of an HRM broadcast frame
//   state_t       : parser FSM states
// ---------------------------------------------------------------------------
package ant_pkg;

    localparam logic [7:0] ANT_SYNC      = 8'hA4;
    localparam logic [7:0] ANT_MSG_BCAST = 8'h4E;
    localparam int         HRM_LEN       = 9;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        ID,
        DATA,
        CSUM
    } state_t;

endpackage

// File: rtl/ant_hrm_parser.sv
// ---------------------------------------------------------------------------
// ant_hrm_parser
// Parses the ANT byte stream from the UART receiver, validates HRM broadcast
// frames and publishes the heart rate with a freshness flag.
//
// Ports:
//   CLOCK_50       in   1  system clock (50 MHz), only clock
//   RESET_N        in   1  asynchronous active-low reset
//   rx_byte        in   8  received byte, valid when received=1
//   received       in   1  single-cycle byte strobe
//   hr_bpm         out  8  last accepted heart rate (bpm)
//   hr_valid       out  1  high while hr_bpm is fresh
//   hr_update      out  1  one-cycle pulse per accepted HRM frame
//   beat_count     out  8  last accepted heartbeat event count
//   csum_err_count out  8  checksum failures, saturating at 255
// ---------------------------------------------------------------------------
module ant_hrm_parser
    import ant_pkg::*;
#(
    parameter int CHANNEL      = 0,
    parameter int MAX_LEN      = 13,
    parameter int GAP_CYCLES   = 50_000,
    parameter int STALE_CYCLES = 100_000_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [7:0] rx_byte,
    input  logic       received,
    output logic [7:0] hr_bpm,
    output logic       hr_valid,
    output logic       hr_update,
    output logic [7:0] beat_count,
    output logic [7:0] csum_err_count
);

    // Payload storage must always hold at least a full HRM page, even if
    // MAX_LEN were configured smaller than HRM_LEN.
    localparam int DEPTH   = (MAX_LEN > HRM_LEN) ? MAX_LEN : HRM_LEN;
    localparam int IDX_W   = $clog2(DEPTH + 1);
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam int STALE_W = $clog2(STALE_CYCLES + 1);

    localparam logic [7:0]         CHANNEL_B  = 8'(CHANNEL);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [STALE_W-1:0] STALE_MAX  = STALE_W'(STALE_CYCLES);
    localparam logic [STALE_W-1:0] STALE_LAST = STALE_W'(STALE_CYCLES - 1);

    state_t             state;
    logic [7:0]         len_r;
    logic [7:0]         msg_id;
    logic [7:0]         data_r [DEPTH];
    logic [IDX_W-1:0]   idx;
    logic [7:0]         csum_acc;
    logic [GAP_W-1:0]   gap_cnt;
    logic [STALE_W-1:0] stale_cnt;

    logic csum_match;
    logic frame_hrm;
    logic accept;
    logic csum_bad;

    // csum_acc already holds the XOR of SYNC..last data byte when in CSUM,
    // so the incoming byte is compared directly against it. The stored frame
    // is complete by then, so the HRM content test is purely combinational.
    assign csum_match = (rx_byte == csum_acc);
    assign frame_hrm  = (msg_id == ANT_MSG_BCAST) &&
                        (len_r == 8'(HRM_LEN)) &&
                        (data_r[0] == CHANNEL_B) &&
                        (data_r[HRM_LEN-1] != 8'h00);
    assign accept     = (state == CSUM) && received && csum_match && frame_hrm;
    assign csum_bad   = (state == CSUM) && received && !csum_match;

    // Frame FSM. Every transition is driven by a byte strobe except the
    // inter-byte gap abort, which returns to HUNT after GAP_CYCLES idle
    // cycles inside a frame. A strobe always clears the gap count, so a
    // strobe arriving on the expiry cycle keeps the frame alive. The
    // checksum is accumulated byte by byte so CSUM needs only one compare.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= HUNT;
            len_r    <= '0;
            msg_id   <= '0;
            idx      <= '0;
            csum_acc <= '0;
            gap_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= '0;
            end
        end else if (received) begin
            gap_cnt <= '0;
            case (state)
                HUNT: begin
                    if (rx_byte == ANT_SYNC) begin
                        csum_acc <= rx_byte;
                        state    <= LEN;
                    end
                end
                LEN: begin
                    if (int'(rx_byte) > MAX_LEN) begin
                        state <= HUNT;
                    end else begin
                        len_r    <= rx_byte;
                        csum_acc <= csum_acc ^ rx_byte;
                        state    <= ID;
                    end
                end
                ID: begin
                    msg_id   <= rx_byte;
                    csum_acc <= csum_acc ^ rx_byte;
                    idx      <= '0;
                    state    <= (len_r == 8'h00) ? CSUM : DATA;
                end
                DATA: begin
                    data_r[idx] <= rx_byte;
                    csum_acc    <= csum_acc ^ rx_byte;
                    if (8'(idx) == len_r - 8'd1) begin
                        state <= CSUM;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                CSUM: begin
                    state <= HUNT;
                end
                default: begin
                    state <= HUNT;
                end
            endcase
        end else if (state != HUNT) begin
            if (gap_cnt == GAP_LAST) begin
                gap_cnt <= '0;
                state   <= HUNT;
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    // Published outputs and freshness timer. An accepted frame loads the
    // heart rate and beat count, pulses hr_update and restarts the stale
    // timer from zero in the same edge. The timer saturates at STALE_CYCLES
    // and drops hr_valid on the edge where it reaches that value; the last
    // heart rate and beat count stay visible. Checksum errors saturate.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            hr_bpm         <= '0;
            hr_valid       <= 1'b0;
            hr_update      <= 1'b0;
            beat_count     <= '0;
            csum_err_count <= '0;
            stale_cnt      <= '0;
        end else begin
            hr_update <= accept;
            if (accept) begin
                hr_bpm     <= data_r[HRM_LEN-1];
                beat_count <= data_r[HRM_LEN-2];
                hr_valid   <= 1'b1;
                stale_cnt  <= '0;
            end else if (stale_cnt != STALE_MAX) begin
                stale_cnt <= stale_cnt + 1'b1;
                if (stale_cnt == STALE_LAST) begin
                    hr_valid <= 1'b0;
                end
            end
            if (csum_bad && (csum_err_count != 8'hFF)) begin
                csum_err_count <= csum_err_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/ant_hrm_parser.md
ANT_HRM_PARSER -- requirements
Module: ant_hrm_parser

Interface
REQ-001 SHALL have parameter CHANNEL, default 0: ANT channel number accepted; frames for other channels are ignored.
REQ-002 SHALL have parameter MAX_LEN, default 13: largest accepted LEN field; a larger LEN aborts the frame.
REQ-003 SHALL have parameter GAP_CYCLES, default 50_000: maximum idle CLOCK_50 cycles between bytes of one frame (1 ms).
REQ-004 SHALL have parameter STALE_CYCLES, default 100_000_000: cycles without an accepted update before the heart rate is declared stale (2 s).
REQ-005 CLOCK_50  input  1  system clock, 50 MHz; the only clock.
REQ-006 RESET_N  input  1  reset, asynchronous, active-low.
REQ-007 rx_byte  input  8  byte from the ANT UART receiver; sampled only when received=1.
REQ-008 received  input  1  single-cycle strobe marking rx_byte valid.
REQ-009 hr_bpm  output  8  last accepted computed heart rate, bpm; feeds AssistanceAlgorithm HeartRate.
REQ-010 hr_valid  output  1  level; 1 while hr_bpm is fresh.
REQ-011 hr_update  output  1  single-cycle pulse on each accepted heart-rate frame.
REQ-012 beat_count  output  8  last accepted heartbeat event count.
REQ-013 csum_err_count  output  8  checksum failures, saturating at 255.

Function
REQ-014 Frame format SHALL be: SYNC 0xA4, LEN, MSG_ID, LEN data bytes, CHK; CHK is the XOR of every byte from SYNC through the last data byte.
REQ-015 FSM states SHALL be HUNT, LEN, ID, DATA, CSUM; transitions occur only on a received strobe, except gap abort.
REQ-016 HUNT: 0xA4 -> LEN; any other byte is discarded.
REQ-017 LEN: LEN > MAX_LEN -> HUNT; otherwise store LEN -> ID.
REQ-018 ID: store MSG_ID; LEN=0 -> CSUM, else -> DATA with data index 0.
REQ-019 DATA: store byte at the current index; after index LEN-1 -> CSUM. An 0xA4 inside DATA is data, not a resync.
REQ-020 CSUM: go to HUNT on any byte; on mismatch, increment csum_err_count (hold at 255).
REQ-021 A frame SHALL be accepted when: checksum matches, MSG_ID=0x4E, LEN=9, data[0]=CHANNEL, and data[8]!=0.
REQ-022 On acceptance: hr_bpm<=data[8], beat_count<=data[7], hr_valid<=1, and hr_update pulses high. All take effect in the cycle after the CHK strobe (latency 1).
REQ-023 A valid frame failing any other REQ-021 condition SHALL leave all outputs unchanged and SHALL NOT count as an error.
REQ-024 Gap abort: in LEN/ID/DATA/CSUM, GAP_CYCLES cycles without a strobe -> HUNT; the partial frame is discarded and no counter changes.
REQ-025 Stale timer SHALL count cycles since the last acceptance. On reaching STALE_CYCLES it SHALL clear hr_valid and hold its count; hr_bpm and beat_count keep their values.
REQ-026 Acceptance restarts the stale timer at 0 in the same cycle that hr_update is asserted.
REQ-027 The gap counter resets on every strobe. If a strobe and gap expiry coincide, the strobe wins.

Reset
REQ-028 RESET_N low SHALL asynchronously force the FSM to HUNT and clear all stored frame bytes and counters. Outputs: hr_bpm=0, hr_valid=0, hr_update=0, beat_count=0, csum_err_count=0.
REQ-029 Reset asserted mid-frame SHALL discard the frame. After release, the first byte is processed in HUNT.

Structure
REQ-030 Package ant_pkg SHALL hold ANT_SYNC=8'hA4, ANT_MSG_BCAST=8'h4E, HRM_LEN=9, and the FSM state enum type.
REQ-031 The design SHALL be a single module with no sub-module. The gap and stale counters SHALL be inline, with widths derived by $clog2 of their parameters.

Verification
REQ-032 Send A4 09 4E 00 00 00 00 00 00 00 12 48 B9 -> hr_bpm=72, beat_count=0x12, hr_valid=1, one hr_update pulse one cycle after B9.
REQ-033 Send the same frame with CHK=B8 -> csum_err_count=1, no hr_update, outputs unchanged. Then send 256 bad frames -> count stays 255.
REQ-034 Send the frame with data[0]=01 and CHK=B8 -> no update and no error. Then send LEN=0x20 followed by a valid frame -> only the valid frame is accepted.
REQ-035 Stop for GAP_CYCLES (override to 100) after the 5th byte, then send the full valid frame -> exactly one acceptance. Repeat with a stray 0xA4 inside DATA -> parsed as data.
REQ-036 With STALE_CYCLES overridden to 1000: accept, wait 1000 cycles -> hr_valid=0 and hr_bpm=72 held. A frame with heart rate 0 (CHK F1) -> no update.
REQ-037 Assert RESET_N mid-DATA -> all outputs 0 immediately. After release, a valid frame is accepted normally.
